// File: rtl/adder_pkg.sv
// Widths and FSM state type shared by the 4-bit adder and its downstream
// sum accumulator, so both sides agree on the sum width.
`timescale 1ns/1ps
package adder_pkg;

  localparam int ADD_IN_W  = 4;
  localparam int ADD_SUM_W = ADD_IN_W + 1;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/adder_sum_accum.sv
// Accumulates bursts of adder sums arriving on a valid/ready handshake and
// presents the burst total, sample count and wrap flag on an output handshake.
`timescale 1ns/1ps
module adder_sum_accum
  import adder_pkg::*;
#(
  parameter int SUM_W = ADD_SUM_W,
  parameter int COUNT = 16,
  parameter int ACC_W = 9,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_total_q, out_total_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             close;
  logic [ACC_W:0]   add_full;
  logic [CNT_W-1:0] cnt_inc;
  logic [ACC_W-1:0] acc_post;
  logic [CNT_W-1:0] cnt_post;
  logic             ovf_post;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_total = out_total_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

  // The extra top bit of add_full is the carry out of the ACC_W-bit add.
  assign accept   = in_valid & in_ready;
  assign add_full = {1'b0, acc_q} + (ACC_W+1)'(in_sum);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Post-add view folds in a sample accepted in the same cycle as the close.
  assign acc_post = accept ? add_full[ACC_W-1:0] : acc_q;
  assign cnt_post = accept ? cnt_inc : cnt_q;
  assign ovf_post = ovf_q | (accept & add_full[ACC_W]);

  assign close = in_ready &
                 ((accept & (cnt_inc == CNT_W'(COUNT))) |
                  (flush & ((cnt_q != '0) | accept)));

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_total_d = out_total_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      ACCUM: begin
        if (close) begin
          out_total_d = acc_post;
          out_count_d = cnt_post;
          out_ovf_d   = ovf_post;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = HOLD;
        end else begin
          acc_d = acc_post;
          cnt_d = cnt_post;
          ovf_d = ovf_post;
        end
      end
      HOLD: begin
        // Result registers keep their value after handoff; only out_valid drops.
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_total_q <= out_total_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_adder_sum_accum.sv
// Scoreboard bench for adder_sum_accum: a 9-bit and a 6-bit accumulator see the
// same stimulus; per-DUT monitors pop expected bursts on each output handshake.
`timescale 1ns/1ps
module tb_adder_sum_accum;
  import adder_pkg::*;

  localparam int SUM_W = ADD_SUM_W;
  localparam int COUNT = 16;
  localparam int CNT_W = 5;
  localparam int ACC_A = 9;
  localparam int ACC_B = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             flush = 1'b0;
  logic [SUM_W-1:0] in_sum = '0;
  logic             ready_ctl = 1'b1;
  logic             rand_bit = 1'b1;
  logic             rand_ready = 1'b0;
  logic             out_ready;

  logic             a_in_ready, a_out_valid, a_out_ovf;
  logic [ACC_A-1:0] a_out_total;
  logic [CNT_W-1:0] a_out_count;
  logic             b_in_ready, b_out_valid, b_out_ovf;
  logic [ACC_B-1:0] b_out_total;
  logic [CNT_W-1:0] b_out_count;

  assign out_ready = rand_ready ? rand_bit : ready_ctl;

  always #5 clk = ~clk;

  adder_sum_accum #(.SUM_W(SUM_W), .COUNT(COUNT), .ACC_W(ACC_A), .CNT_W(CNT_W)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_sum(in_sum),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_total(a_out_total), .out_count(a_out_count), .out_ovf(a_out_ovf));

  adder_sum_accum #(.SUM_W(SUM_W), .COUNT(COUNT), .ACC_W(ACC_B), .CNT_W(CNT_W)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_sum(in_sum),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_total(b_out_total), .out_count(b_out_count), .out_ovf(b_out_ovf));

  typedef struct {
    int total;
    int count;
    bit ovf;
  } res_t;

  res_t qa[$];
  res_t qb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected result of a burst whose samples add up to sum over n samples.
  task automatic expect_burst(input int sum, input int n);
    res_t r;
    r.total = sum % (1 << ACC_A);
    r.count = n;
    r.ovf   = (sum >= (1 << ACC_A));
    qa.push_back(r);
    r.total = sum % (1 << ACC_B);
    r.ovf   = (sum >= (1 << ACC_B));
    qb.push_back(r);
  endtask

  always @(posedge clk) begin
    #1 rand_bit = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    res_t e;
    if (!rst && a_out_valid && out_ready) begin
      if (qa.size() == 0) check("a_unexpected_result", 1, 0);
      else begin
        e = qa.pop_front();
        check("a_total", int'(a_out_total), e.total);
        check("a_count", int'(a_out_count), e.count);
        check("a_ovf", int'(a_out_ovf), int'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (!rst && b_out_valid && out_ready) begin
      if (qb.size() == 0) check("b_unexpected_result", 1, 0);
      else begin
        e = qb.pop_front();
        check("b_total", int'(b_out_total), e.total);
        check("b_count", int'(b_out_count), e.count);
        check("b_ovf", int'(b_out_ovf), int'(e.ovf));
      end
    end
  end

  // All tasks below start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int sum, input bit fl);
    int waited = 0;
    in_valid = 1'b1;
    in_sum   = SUM_W'(sum);
    flush    = fl;
    @(negedge clk);
    while (!a_in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!a_in_ready) check("send_in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((qa.size() != 0 || qb.size() != 0) && waited < 200) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain_a_pending", qa.size(), 0);
    check("drain_b_pending", qb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int samples[16];
    int len;
    int sum;
    bit mode;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_in_ready", int'(a_in_ready), 1);
    check("rst_out_total", int'(a_out_total), 0);
    check("rst_out_count", int'(a_out_count), 0);
    check("rst_out_ovf", int'(a_out_ovf), 0);
    check("rst_b_out_valid", int'(b_out_valid), 0);
    @(posedge clk);
    #1;

    // 16 x 30 back-to-back: A 480 no wrap, B 480 mod 64 = 32 wrapped
    expect_burst(480, 16);
    for (int i = 0; i < 16; i++) send(30, 1'b0);
    @(negedge clk);
    check("t1_out_valid_high", int'(a_out_valid), 1);
    @(negedge clk);
    check("t1_out_valid_one_cycle", int'(a_out_valid), 0);
    @(posedge clk);
    #1;

    // 1..5 then flush pulse; then a flush with nothing accumulated
    expect_burst(15, 5);
    for (int i = 1; i <= 5; i++) send(i, 1'b0);
    do_flush();
    idle(3);
    do_flush();
    idle(4);
    @(negedge clk);
    check("t2_idle_flush_no_valid", int'(a_out_valid), 0);
    check("t2_idle_flush_no_result", qa.size(), 0);
    @(posedge clk);
    #1;

    // 30,30,10 flush: B sees 70 mod 64 = 6 with wrap; next burst wrap flag clear
    expect_burst(70, 3);
    send(30, 1'b0);
    send(30, 1'b0);
    send(10, 1'b0);
    do_flush();
    idle(3);
    expect_burst(10, 2);
    send(5, 1'b0);
    send(5, 1'b0);
    do_flush();
    idle(3);

    // Backpressure: result held 5 cycles while a sample of 31 is offered
    ready_ctl = 1'b0;
    expect_burst(18, 4);
    send(3, 1'b0);
    send(4, 1'b0);
    send(5, 1'b0);
    send(6, 1'b0);
    do_flush();
    in_valid = 1'b1;
    in_sum   = SUM_W'(31);
    repeat (5) begin
      @(negedge clk);
      check("t4_in_ready_low", int'(a_in_ready), 0);
      check("t4_out_valid_held", int'(a_out_valid), 1);
      check("t4_total_stable", int'(a_out_total), 18);
      check("t4_count_stable", int'(a_out_count), 4);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    ready_ctl = 1'b1;
    @(negedge clk);
    check("t4_handoff_in_ready_low", int'(a_in_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t4_after_handoff_valid", int'(a_out_valid), 0);
    check("t4_after_handoff_in_ready", int'(a_in_ready), 1);
    @(posedge clk);
    #1;
    expect_burst(1, 1);
    send(1, 1'b0);
    do_flush();
    idle(3);

    // Flush coincident with accepted sample 7 after 2,2,2
    expect_burst(13, 4);
    send(2, 1'b0);
    send(2, 1'b0);
    send(2, 1'b0);
    send(7, 1'b1);
    idle(3);

    // Random bursts with gapped in_valid and random out_ready
    rand_ready = 1'b1;
    for (int b = 0; b < 200; b++) begin
      len  = $urandom_range(1, 16);
      mode = 1'($urandom_range(0, 1));
      sum  = 0;
      for (int k = 0; k < len; k++) begin
        samples[k] = $urandom_range(0, 31);
        sum += samples[k];
      end
      expect_burst(sum, len);
      for (int k = 0; k < len; k++) begin
        idle($urandom_range(0, 2));
        send(samples[k], (k == len - 1) && (len < COUNT) && mode);
      end
      if (len < COUNT && !mode) do_flush();
    end
    rand_ready = 1'b0;
    ready_ctl  = 1'b1;
    wait_drain();

    // Reset mid-burst after 9 samples
    for (int i = 0; i < 9; i++) send(3, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_mid_out_valid", int'(a_out_valid), 0);
    check("t6_mid_in_ready", int'(a_in_ready), 1);
    check("t6_mid_out_count_cleared", int'(a_out_count), 0);
    @(posedge clk);
    #1;

    // Reset while a result is held
    ready_ctl = 1'b0;
    send(4, 1'b0);
    send(4, 1'b0);
    do_flush();
    @(negedge clk);
    check("t6_hold_entered", int'(a_out_valid), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    ready_ctl = 1'b1;
    @(negedge clk);
    check("t6_hold_out_valid", int'(a_out_valid), 0);
    check("t6_hold_in_ready", int'(a_in_ready), 1);
    check("t6_hold_b_out_valid", int'(b_out_valid), 0);
    @(posedge clk);
    #1;
    expect_burst(112, 16);
    for (int i = 0; i < 16; i++) send(7, 1'b0);
    idle(3);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
